// File: rtl/wdt_sleep_ctrl_pkg.sv
// wdt_sleep_ctrl_pkg: shared state encodings, widths and postscaler helper for the watchdog/sleep controller
package wdt_sleep_ctrl_pkg;
   localparam int PSC_W = 7;
   localparam int PS_W = 3;
   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_RUN = 2'd0;
   localparam logic [1:0] ST_SLEEP = 2'd1;
   localparam logic [1:0] ST_WDT_RST = 2'd2;
   localparam logic [1:0] ST_FLAG_WR = 2'd3;
   function automatic logic [PSC_W-1:0] ps_limit(input logic psa, input logic [PS_W-1:0] ps);
      return psa ? PSC_W'((32'd1 << ps) - 32'd1) : '0;
   endfunction
endpackage

// File: rtl/wdt_prescaler.sv
// wdt_prescaler: base period counter plus optional postscaler (WDT_POSTSCALER_EN), flags timeout on the final wrap
module wdt_prescaler
   import wdt_sleep_ctrl_pkg::*;
#(
   parameter int WDT_BASE = 1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            count_en,
   input  logic            clear,
   input  logic            psa,
   input  logic [PS_W-1:0] ps,
   output logic            timeout
);
   logic [15:0] base;
   logic        wrap;
   assign wrap = count_en && base == 16'(WDT_BASE - 1);
`ifdef WDT_POSTSCALER_EN
   logic [PSC_W-1:0] psc;
   assign timeout = wrap && psc >= ps_limit(psa, ps);
   // postscaler counts base wraps; a lowered ratio fires on the very next wrap
   always_ff @(posedge clk)
      if (rst || clear) psc <= '0;
      else if (wrap) psc <= timeout ? '0 : psc + 1'b1;
`else
   logic unused;
   assign unused = ^{psa, ps};
   assign timeout = wrap;
`endif
   // base counter runs only while enabled and wraps at the configured period
   always_ff @(posedge clk)
      if (rst || clear) base <= '0;
      else if (count_en) base <= wrap ? '0 : base + 16'd1;
endmodule

// File: rtl/wdt_sleep_ctrl.sv
// wdt_sleep_ctrl: watchdog and SLEEP sequencing with TO/PD status writes; postscaler gated by WDT_POSTSCALER_EN
module wdt_sleep_ctrl
   import wdt_sleep_ctrl_pkg::*;
#(
   parameter int WDT_BASE = 1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wdt_en,
   input  logic            psa,
   input  logic [PS_W-1:0] ps,
   input  logic            clrwdt,
   input  logic            sleep_instr,
   input  logic            wake_event,
   output logic            n_to_wr_en,
   output logic            n_to_in,
   output logic            n_pd_wr_en,
   output logic            n_pd_in,
   output logic            sleeping,
   output logic            wdt_rst_req,
   output logic            wake
);
   state_t state, nxt;
   logic in_run, in_sleep, timeout, clear, do_sleep, do_clr, do_wake, sleep_to, wr;
   assign in_run = state == ST_RUN;
   assign in_sleep = state == ST_SLEEP;
   assign do_sleep = in_run && sleep_instr;
   assign do_clr = in_run && clrwdt && !sleep_instr;
   assign do_wake = in_sleep && wake_event;
   assign sleep_to = in_sleep && !wake_event && timeout;
   assign clear = !wdt_en || state == ST_WDT_RST || state == ST_FLAG_WR || do_sleep || do_clr || do_wake;
   assign wr = do_sleep || do_clr || sleep_to || nxt == ST_FLAG_WR;
   wdt_prescaler #(.WDT_BASE(WDT_BASE)) u_pre (
      .clk(clk),
      .rst(rst),
      .count_en(wdt_en && (in_run || in_sleep)),
      .clear(clear),
      .psa(psa),
      .ps(ps),
      .timeout(timeout)
   );
   // next state: sleep beats clrwdt beats timeout in RUN, wake beats timeout in SLEEP
   always_comb
      nxt = in_run ? (do_sleep ? ST_SLEEP : (!clrwdt && timeout) ? ST_WDT_RST : ST_RUN)
          : in_sleep ? ((wake_event || timeout) ? ST_RUN : ST_SLEEP)
          : state == ST_WDT_RST ? ST_FLAG_WR : ST_RUN;
   // state and registered single-cycle strobes; flag write lands after the core reset
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_RUN;
         sleeping <= 1'b0;
         wdt_rst_req <= 1'b0;
         wake <= 1'b0;
         n_to_wr_en <= 1'b0;
         n_to_in <= 1'b0;
         n_pd_wr_en <= 1'b0;
         n_pd_in <= 1'b0;
      end else begin
         state <= nxt;
         sleeping <= nxt == ST_SLEEP;
         wdt_rst_req <= nxt == ST_WDT_RST;
         wake <= in_sleep && (wake_event || timeout);
         n_to_wr_en <= wr;
         n_pd_wr_en <= wr;
         n_to_in <= do_sleep || do_clr;
         n_pd_in <= do_clr || nxt == ST_FLAG_WR;
      end
endmodule
